// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce_gen switch emulator:
// FSM state encoding, LFSR polynomial/seed and small helper functions.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

  // One Galois step: shift right, fold taps in when a 1 falls out.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

  function automatic int counter_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr8.sv
// 8-bit Galois LFSR used as the bounce noise source. A load of zero is
// replaced by the default seed so the register can never lock up.
module lfsr8
  import bounce_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       advance,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (load_value == 8'h00) ? LFSR_DEFAULT_SEED : load_value;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Mechanical switch emulator: bounce burst from an LFSR, then a clean level.
// Optional BOUNCE_GEN_SEED_EN adds a per-event seed port.
//
// state  | meaning
// IDLE   | line holds last value, waiting for start
// BOUNCE | line follows lfsr[0], LFSR stepping each cycle
// SETTLE | line driven to latched target, then done is raised
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int BOUNCE_LEN = 32,
  parameter int SETTLE_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       target_level,
`ifdef BOUNCE_GEN_SEED_EN
  input  logic [7:0] seed,
`endif
  output logic       button_out,
  output logic       busy,
  output logic       done
);

  localparam int CW = counter_width(BOUNCE_LEN, SETTLE_LEN);
  localparam logic [CW-1:0] BOUNCE_LOAD = (BOUNCE_LEN > 0) ? CW'(BOUNCE_LEN - 1) : '0;
  // SETTLE spends one extra hand-off cycle after its last target write, so
  // done lands BOUNCE_LEN+SETTLE_LEN+1 cycles after start with the line at target.
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_LEN);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          target_q, target_nxt;
  logic          out_nxt, done_nxt;
  logic          lfsr_adv, lfsr_load;
  logic [7:0]    lfsr_q, lfsr_seed;
  logic          unused_lfsr_hi;

`ifdef BOUNCE_GEN_SEED_EN
  assign lfsr_load = (state == IDLE) && start;
  assign lfsr_seed = seed;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = LFSR_DEFAULT_SEED;
`endif

  lfsr8 u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (lfsr_load),
    .load_value (lfsr_seed),
    .advance    (lfsr_adv),
    .state      (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[7:1];
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    target_nxt = target_q;
    out_nxt    = button_out;
    done_nxt   = 1'b0;
    lfsr_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          target_nxt = target_level;
          if (BOUNCE_LEN > 0) begin
            state_nxt = BOUNCE;
            count_nxt = BOUNCE_LOAD;
          end else begin
            state_nxt = SETTLE;
            count_nxt = SETTLE_LOAD;
          end
        end
      end
      BOUNCE: begin
        out_nxt  = lfsr_q[0];
        lfsr_adv = 1'b1;
        if (count == '0) begin
          state_nxt = SETTLE;
          count_nxt = SETTLE_LOAD;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
      SETTLE: begin
        out_nxt = target_q;
        if (count == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      target_q   <= 1'b0;
      button_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      target_q   <= target_nxt;
      button_out <= out_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: timeline model checked every cycle on two
// instances (32/16 and 0/4), plus directed literal expectations.
module tb_bounce_gen;

  localparam int B_A = 32;
  localparam int S_A = 16;
  localparam int B_Z = 0;
  localparam int S_Z = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic target_level = 1'b0;
`ifdef BOUNCE_GEN_SEED_EN
  logic [7:0] seed = 8'h00;
`endif
  logic bo, busy, done;
  logic bo0, busy0, done0;

  always #5 clk = ~clk;

  bounce_gen #(.BOUNCE_LEN(B_A), .SETTLE_LEN(S_A)) dut (
    .clk(clk), .reset(reset), .start(start), .target_level(target_level),
`ifdef BOUNCE_GEN_SEED_EN
    .seed(seed),
`endif
    .button_out(bo), .busy(busy), .done(done)
  );

  bounce_gen #(.BOUNCE_LEN(B_Z), .SETTLE_LEN(S_Z)) dut0 (
    .clk(clk), .reset(reset), .start(start), .target_level(target_level),
`ifdef BOUNCE_GEN_SEED_EN
    .seed(seed),
`endif
    .button_out(bo0), .busy(busy0), .done(done0)
  );

  // t = cycles since the accepting edge (-1 when idle); the event occupies
  // t = 0..b+s with bounce bits at 1..b, target at b+1..b+s, done at b+s+1.
  typedef struct packed {
    int         t;
    logic [7:0] lfsr;
    logic       out;
    logic       tgt;
  } model_t;

  model_t m  = '{t: -1, lfsr: 8'hA5, out: 1'b0, tgt: 1'b0};
  model_t m0 = '{t: -1, lfsr: 8'hA5, out: 1'b0, tgt: 1'b0};
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  function automatic model_t step(input model_t cur, input int b, input int s);
    model_t n;
    n = cur;
    if (reset) begin
      n.t = -1; n.lfsr = 8'hA5; n.out = 1'b0;
    end else if (cur.t < 0 || cur.t == b + s + 1) begin
      if (start) begin
        n.t = 0;
        n.tgt = target_level;
`ifdef BOUNCE_GEN_SEED_EN
        n.lfsr = (seed == 8'h00) ? 8'hA5 : seed;
`endif
      end else begin
        n.t = -1;
      end
    end else begin
      n.t = cur.t + 1;
      if (n.t <= b) begin
        n.out = cur.lfsr[0];
        n.lfsr = lfsr_next(cur.lfsr);
      end else if (n.t <= b + s) begin
        n.out = cur.tgt;
      end
    end
    return n;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_bit(name, done, 1'b1);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc++;
    m  = step(m, B_A, S_A);
    m0 = step(m0, B_Z, S_Z);
    if (reset) check_en = 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_bit("model_out",   bo,    m.out);
      check_bit("model_busy",  busy,  (m.t >= 0 && m.t <= B_A + S_A));
      check_bit("model_done",  done,  (m.t == B_A + S_A + 1));
      check_bit("model0_out",  bo0,   m0.out);
      check_bit("model0_busy", busy0, (m0.t >= 0 && m0.t <= B_Z + S_Z));
      check_bit("model0_done", done0, (m0.t == B_Z + S_Z + 1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_bits;
    int dones;
    exp_bits = 8'h15;  // first 8 bits from A5: 1,0,1,0,1,0,0,0

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_bit("idle_out", bo, 1'b0);
      check_bit("idle_busy", busy, 1'b0);
      check_bit("idle_done", done, 1'b0);
    end

    // Default event, target 1; dut0 runs its short event alongside.
    start = 1'b1; target_level = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_bit("a_busy_c0", busy, 1'b1);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c <= 8) check_bit("a_bounce_bit", bo, exp_bits[3'(c - 1)]);
      if (c == 8) check_word("model_lfsr_after8", {24'h0, m.lfsr}, 32'h13);
      if (c == 4) begin
        check_bit("z_out_c4", bo0, 1'b1);
        check_bit("z_done_c4", done0, 1'b0);
      end
      if (c == 5) check_bit("z_done_c5", done0, 1'b1);
      if (c == 33 || c == 48) check_bit("a_settle_out", bo, 1'b1);
      if (c == 48) begin
        check_bit("a_busy_c48", busy, 1'b1);
        check_bit("a_done_c48", done, 1'b0);
      end
      if (c == 49) begin
        check_bit("a_done_c49", done, 1'b1);
        check_bit("a_busy_c49", busy, 1'b0);
      end
      if (c == 50) check_bit("a_done_c50", done, 1'b0);
    end

    // dut0 from line=1 to target 0: no bounce, 4 cycles of 0, done at 5.
    start = 1'b1; target_level = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) check_bit("z_target0_out", bo0, 1'b0);
      if (c == 4) check_bit("z_busy_c4", busy0, 1'b1);
      if (c == 5) check_bit("z_done_target0", done0, 1'b1);
    end
    wait_done("b_done_timeout", 80);

    // start held high: single event, second accepted right after done.
    start = 1'b1; target_level = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 49) begin
        check_bit("c_done_c49", done, 1'b1);
        check_bit("c_busy_c49", busy, 1'b0);
      end
      if (c == 50) check_bit("c_restart_busy", busy, 1'b1);
    end
    start = 1'b0;
    wait_done("c_done_timeout", 80);

    // Reset at cycle 10 of a bounce.
    start = 1'b1; target_level = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_bit("d_rst_out", bo, 1'b0);
    check_bit("d_rst_busy", busy, 1'b0);
    reset = 1'b0;
    dones = 0;
    repeat (55) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_word("d_no_done", dones, 0);
    start = 1'b1; target_level = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check_bit("d_replay_bit", bo, exp_bits[3'(c - 1)]);
    end
    wait_done("d_done_timeout", 80);

`ifdef BOUNCE_GEN_SEED_EN
    begin
      logic [31:0] cap0, cap1;
      logic [7:0] hist;
      logic deb;
      cap0 = '0; cap1 = '0;
      seed = 8'h00; target_level = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 32; c++) begin
        @(negedge clk);
        cap0[5'(c - 1)] = bo;
      end
      wait_done("s0_done_timeout", 40);
      seed = 8'hA5; start = 1'b1;
      hist = 8'hFF; deb = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 49; c++) begin
        @(negedge clk);
        if (c <= 32) cap1[5'(c - 1)] = bo;
        hist = {hist[6:0], bo};
        if (hist == 8'hFF) deb = 1'b1;
        else if (hist == 8'h00) deb = 1'b0;
      end
      check_word("seed_zero_vs_a5", cap0, cap1);
      check_bit("debounced_target", deb, 1'b0);
      wait_done("s1_done_timeout", 10);
    end
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
